// File: rtl/retire_pkg.sv
// Shared definitions for the commit stage: ROB entry layout (common with rename
// and the ROB), register-file geometry and the retire FSM encoding.
package retire_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int LOG_ARCH = 5;
  localparam int LOG_PHYS = 6;

  // ROB entry bit positions, LSB upward.
  localparam int ROB_ARCH_LSB     = 0;
  localparam int ROB_PHYS_LSB     = ROB_ARCH_LSB + LOG_ARCH;
  localparam int ROB_HAS_DEST_BIT = ROB_PHYS_LSB + LOG_PHYS;
  localparam int ROB_ALT_REQ_BIT  = ROB_HAS_DEST_BIT + 1;
  localparam int ROB_ALTPC_LSB    = ROB_ALT_REQ_BIT + 1;
  localparam int ROB_ADDR_LSB     = ROB_ALTPC_LSB + 32;
  localparam int ROB_INSTR_LSB    = ROB_ADDR_LSB + 32;
  localparam int ROB_DONE_BIT     = ROB_INSTR_LSB + 32;
  localparam int ROB_ENTRY_BITS   = ROB_DONE_BIT + 1;

  typedef logic [LOG_ARCH-1:0] arch_t;
  typedef logic [LOG_PHYS-1:0] phys_t;
  typedef logic [NUM_ARCH-1:0][LOG_PHYS-1:0] rat_t;

  // Field order matches the bit positions above.
  typedef struct packed {
    logic        done;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] alt_pc;
    logic        request_alt_pc;
    logic        has_dest;
    phys_t       phys;
    arch_t       arch;
  } rob_entry_t;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_REBUILD = 2'd2;

endpackage

// File: rtl/retire_rrat.sv
// Retirement RAT plus the Mapped vector (one bit per physical register that the
// R-RAT currently names). Single write port returning the displaced mapping.
module retire_rrat
  import retire_pkg::*;
(
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             wr_en,
  input  logic [LOG_ARCH-1:0]              wr_arch,
  input  logic [LOG_PHYS-1:0]              wr_phys,
  output logic [LOG_PHYS-1:0]              old_phys,
  output logic [NUM_ARCH-1:0][LOG_PHYS-1:0] rrat_map,
  output logic [NUM_PHYS-1:0]              mapped
);

  rat_t                rrat_map_q, rrat_map_d;
  logic [NUM_PHYS-1:0] mapped_q, mapped_d;

  assign old_phys = rrat_map_q[wr_arch];

  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    rrat_map_d = rrat_map_q;
    mapped_d   = mapped_q;
    if (wr_en) begin
      mapped_d[old_phys]  = 1'b0;
      mapped_d[wr_phys]   = 1'b1;
      rrat_map_d[wr_arch] = wr_phys;
    end
  end

  // NOTE: the R-RAT is a flop array rather than a RAM, so it can be reset
  // to the identity map; a RAM-style memory would not take a reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rrat_map_q[i] <= phys_t'(i);
      end
      mapped_q <= {{(NUM_PHYS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      rrat_map_q <= rrat_map_d;
      mapped_q   <= mapped_d;
    end
  end

  assign rrat_map = rrat_map_q;
  assign mapped   = mapped_q;

endmodule

// File: rtl/retire.sv
// Commit stage: retires one completed ROB head per cycle, maintains the R-RAT,
// and on a misprediction flushes, restores the F-RAT and rebuilds the free list.
module retire
  import retire_pkg::*;
(
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              ROB_head_valid,
  input  logic [ROB_ENTRY_BITS-1:0]         ROB_head_entry,
  output logic                              ROB_pop,
  output logic                              Free_push,
  output logic [LOG_PHYS-1:0]               Free_reg,
  output logic                              Free_list_clear,
  output logic                              Frat_restore,
  output logic                              Busy_clear,
  output logic                              Flush,
  output logic                              Redirect_valid,
  output logic [31:0]                       Redirect_PC,
  output logic [NUM_ARCH-1:0][LOG_PHYS-1:0] Rrat_map,
  output logic                              Rebuilding,
  output logic [31:0]                       Retired_count
);

  rob_entry_t head;
  assign head = rob_entry_t'(ROB_head_entry);

  // instr and addr travel with the entry but are not needed to commit.
  logic unused_fields;
  assign unused_fields = ^{head.instr, head.addr};

  logic [1:0]  state_q, state_d;
  phys_t       walk_q, walk_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        free_push_q, free_push_d;
  phys_t       free_reg_q, free_reg_d;
  logic        recover_q, recover_d;

  logic                pop;
  logic                rat_wr_en;
  phys_t               old_phys;
  logic [NUM_PHYS-1:0] mapped;

  retire_rrat u_rrat (
    .CLK      (CLK),
    .RESET    (RESET),
    .wr_en    (rat_wr_en),
    .wr_arch  (head.arch),
    .wr_phys  (head.phys),
    .old_phys (old_phys),
    .rrat_map (Rrat_map),
    .mapped   (mapped)
  );

  always_comb begin
    state_d         = state_q;
    walk_d          = walk_q;
    retired_count_d = retired_count_q;
    redirect_pc_d   = redirect_pc_q;
    free_push_d     = 1'b0;
    free_reg_d      = free_reg_q;
    recover_d       = 1'b0;
    rat_wr_en       = 1'b0;
    pop             = 1'b0;

    case (state_q)
      ST_RUN: begin
        pop = ROB_head_valid & head.done;
        if (pop) begin
          retired_count_d = retired_count_q + 32'd1;
          if (head.has_dest) begin
            // A register allocated for $0 is never architecturally visible.
            if (head.arch == '0) begin
              free_push_d = 1'b1;
              free_reg_d  = head.phys;
            end else if (head.phys != old_phys) begin
              rat_wr_en   = 1'b1;
              free_push_d = 1'b1;
              free_reg_d  = old_phys;
            end
          end
          // The mispredicting instruction still commits its destination.
          if (head.request_alt_pc) begin
            redirect_pc_d = head.alt_pc;
            recover_d     = 1'b1;
            state_d       = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        walk_d  = '0;
        state_d = ST_REBUILD;
      end

      ST_REBUILD: begin
        if (!mapped[walk_q]) begin
          free_push_d = 1'b1;
          free_reg_d  = walk_q;
        end
        walk_d = walk_q + 1'b1;
        if (walk_q == phys_t'(NUM_PHYS-1)) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q         <= ST_RUN;
      walk_q          <= '0;
      retired_count_q <= '0;
      redirect_pc_q   <= '0;
      free_push_q     <= 1'b0;
      free_reg_q      <= '0;
      recover_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      walk_q          <= walk_d;
      retired_count_q <= retired_count_d;
      redirect_pc_q   <= redirect_pc_d;
      free_push_q     <= free_push_d;
      free_reg_q      <= free_reg_d;
      recover_q       <= recover_d;
    end
  end

  assign ROB_pop       = pop;
  assign Free_push     = free_push_q;
  assign Free_reg      = free_reg_q;
  assign Redirect_PC   = redirect_pc_q;
  assign Retired_count = retired_count_q;
  assign Rebuilding    = (state_q != ST_RUN);

  // All recovery pulses coincide with the single FLUSH cycle.
  assign Flush           = recover_q;
  assign Redirect_valid  = recover_q;
  assign Frat_restore    = recover_q;
  assign Busy_clear      = recover_q;
  assign Free_list_clear = recover_q;

endmodule

// File: tb/tb_retire.sv
// Randomised self-checking bench for retire against a behavioural R-RAT model.
`timescale 1ns/1ps
module tb_retire;
  import retire_pkg::*;

  logic                              CLK = 1'b0;
  logic                              RESET = 1'b0;
  logic                              ROB_head_valid = 1'b0;
  logic [ROB_ENTRY_BITS-1:0]         ROB_head_entry = '0;
  logic                              ROB_pop;
  logic                              Free_push;
  logic [LOG_PHYS-1:0]               Free_reg;
  logic                              Free_list_clear;
  logic                              Frat_restore;
  logic                              Busy_clear;
  logic                              Flush;
  logic                              Redirect_valid;
  logic [31:0]                       Redirect_PC;
  logic [NUM_ARCH-1:0][LOG_PHYS-1:0] Rrat_map;
  logic                              Rebuilding;
  logic [31:0]                       Retired_count;

  always #5 CLK = ~CLK;

  retire dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ROB_head_valid  (ROB_head_valid),
    .ROB_head_entry  (ROB_head_entry),
    .ROB_pop         (ROB_pop),
    .Free_push       (Free_push),
    .Free_reg        (Free_reg),
    .Free_list_clear (Free_list_clear),
    .Frat_restore    (Frat_restore),
    .Busy_clear      (Busy_clear),
    .Flush           (Flush),
    .Redirect_valid  (Redirect_valid),
    .Redirect_PC     (Redirect_PC),
    .Rrat_map        (Rrat_map),
    .Rebuilding      (Rebuilding),
    .Retired_count   (Retired_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: architectural map, retire counter, redirect and last freed reg.
  phys_t       m_map [NUM_ARCH];
  logic [31:0] m_count;
  logic [31:0] m_redirect;
  phys_t       m_free_reg;

  function automatic void model_reset();
    for (int i = 0; i < NUM_ARCH; i++) m_map[i] = phys_t'(i);
    m_count    = '0;
    m_redirect = '0;
    m_free_reg = '0;
  endfunction

  function automatic bit is_mapped(input phys_t p);
    for (int i = 0; i < NUM_ARCH; i++) if (m_map[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rat_t model_rat();
    rat_t r;
    for (int i = 0; i < NUM_ARCH; i++) r[i] = m_map[i];
    return r;
  endfunction

  function automatic phys_t pick_free();
    phys_t p;
    for (int t = 0; t < 200; t++) begin
      p = phys_t'($urandom_range(0, NUM_PHYS-1));
      if (!is_mapped(p)) return p;
    end
    for (int k = 0; k < NUM_PHYS; k++) if (!is_mapped(phys_t'(k))) return phys_t'(k);
    return '0;
  endfunction

  function automatic rob_entry_t mk(input bit done, input bit rap, input logic [31:0] alt,
                                    input bit h, input arch_t a, input phys_t p);
    rob_entry_t e;
    e.done           = done;
    e.instr          = $urandom;
    e.addr           = $urandom;
    e.alt_pc         = alt;
    e.request_alt_pc = rap;
    e.has_dest       = h;
    e.phys           = p;
    e.arch           = a;
    return e;
  endfunction

  task automatic do_reset();
    RESET          = 1'b0;
    ROB_head_valid = 1'b0;
    ROB_head_entry = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    model_reset();
  endtask

  // Walks the FLUSH cycle (already sampled) and the rebuild; optional reset at iteration abort_at.
  task automatic rebuild_phase(input int abort_at);
    phys_t exp_q[$];
    phys_t want;
    int    pushes = 0;
    int    reb    = 1;
    for (int k = 0; k < NUM_PHYS; k++) if (!is_mapped(phys_t'(k))) exp_q.push_back(phys_t'(k));
    for (int i = 1; i <= NUM_PHYS + 1; i++) begin
      ROB_head_valid = 1'b1;
      ROB_head_entry = mk(1'b1, 1'b0, 32'h0, 1'b1, arch_t'($urandom_range(1, NUM_ARCH-1)),
                          phys_t'($urandom_range(0, NUM_PHYS-1)));
      @(negedge CLK);
      check("pop_during_recovery", 256'(ROB_pop), 256'(0));
      if (i == abort_at) RESET = 1'b0;
      @(posedge CLK);
      #1;
      if (i == abort_at) begin
        RESET = 1'b1;
        model_reset();
        check("abort_free_push", 256'(Free_push), 256'(0));
        check("abort_rebuilding", 256'(Rebuilding), 256'(0));
        check("abort_rrat_identity", 256'(Rrat_map), 256'(model_rat()));
        check("abort_retired_count", 256'(Retired_count), 256'(m_count));
        return;
      end
      if (Free_push) begin
        pushes++;
        if (exp_q.size() == 0) begin
          check("rebuild_extra_push", 256'(pushes), 256'(NUM_PHYS - NUM_ARCH));
        end else begin
          want = exp_q.pop_front();
          check("rebuild_push_reg", 256'(Free_reg), 256'(want));
          m_free_reg = want;
        end
      end
      if (Rebuilding) reb++;
      check("recovery_pulses_low",
            256'({Flush, Redirect_valid, Frat_restore, Busy_clear, Free_list_clear}), 256'(0));
    end
    check("rebuild_push_count", 256'(pushes), 256'(NUM_PHYS - NUM_ARCH));
    check("rebuild_missing", 256'(exp_q.size()), 256'(0));
    check("rebuilding_cycles", 256'(reb), 256'(NUM_PHYS + 1));
  endtask

  // One RUN-state cycle: drive the head, check pop, then the registered results.
  task automatic run_cycle(input logic v, input rob_entry_t e, input int abort_at = -1);
    bit    exp_pop, exp_push, exp_rec;
    arch_t a;
    phys_t p;
    ROB_head_valid = v;
    ROB_head_entry = e;
    a        = e.arch;
    p        = e.phys;
    exp_pop  = v && e.done;
    exp_push = 1'b0;
    exp_rec  = 1'b0;
    @(negedge CLK);
    check("rob_pop", 256'(ROB_pop), 256'(exp_pop));
    if (exp_pop) begin
      m_count = m_count + 32'd1;
      if (e.has_dest) begin
        if (a == '0) begin
          exp_push   = 1'b1;
          m_free_reg = p;
        end else if (p != m_map[a]) begin
          exp_push   = 1'b1;
          m_free_reg = m_map[a];
          m_map[a]   = p;
        end
      end
      if (e.request_alt_pc) begin
        exp_rec    = 1'b1;
        m_redirect = e.alt_pc;
      end
    end
    @(posedge CLK);
    #1;
    check("free_push", 256'(Free_push), 256'(exp_push));
    check("free_reg", 256'(Free_reg), 256'(m_free_reg));
    check("rrat_map", 256'(Rrat_map), 256'(model_rat()));
    check("retired_count", 256'(Retired_count), 256'(m_count));
    check("redirect_pc", 256'(Redirect_PC), 256'(m_redirect));
    check("recovery_pulses",
          256'({Flush, Redirect_valid, Frat_restore, Busy_clear, Free_list_clear, Rebuilding}),
          256'({6{exp_rec}}));
    if (exp_rec) rebuild_phase(abort_at);
  endtask

  initial begin
    do_reset();
    check("reset_rrat5", 256'(Rrat_map[5]), 256'(5));
    check("reset_rrat31", 256'(Rrat_map[31]), 256'(31));
    check("reset_rrat_all", 256'(Rrat_map), 256'(model_rat()));
    check("reset_retired_count", 256'(Retired_count), 256'(0));
    check("reset_free_push", 256'(Free_push), 256'(0));
    check("reset_rob_pop", 256'(ROB_pop), 256'(0));

    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 6'd40));
    check("first_retire_free_reg", 256'(Free_reg), 256'(3));
    for (int i = 0; i < 5; i++) run_cycle(1'b1, mk(1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 6'd41));
    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd7, 6'd41));
    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd0, 6'd45));
    check("zero_reg_freed", 256'(Free_reg), 256'(45));
    check("rrat0_untouched", 256'(Rrat_map[0]), 256'(0));

    // Misprediction after arch 3 -> phys 40.
    do_reset();
    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 6'd40));
    run_cycle(1'b1, mk(1'b1, 1'b1, 32'h0040_0100, 1'b0, 5'd0, 6'd0));
    check("redirect_after_rebuild", 256'(Redirect_PC), 256'(32'h0040_0100));
    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 6'd50));

    for (int n = 0; n < 300; n++) begin
      bit    v, d, h, rap;
      arch_t a;
      phys_t p;
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 3) != 0);
      h   = ($urandom_range(0, 3) != 0);
      rap = ($urandom_range(0, 39) == 0);
      a   = arch_t'($urandom_range(0, NUM_ARCH-1));
      if ($urandom_range(0, 7) == 0) a = '0;
      if (a != '0 && $urandom_range(0, 4) == 0) p = m_map[a];
      else p = pick_free();
      run_cycle(v, mk(d, rap, $urandom, h, a, p));
    end

    // Reset in the middle of a rebuild.
    run_cycle(1'b1, mk(1'b1, 1'b1, 32'h0040_0200, 1'b1, 5'd4, pick_free()), 11);
    run_cycle(1'b1, mk(1'b1, 1'b0, 32'h0, 1'b1, 5'd6, 6'd48));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/retire.md
Name: retire

Overview:
- Commit stage at the head of the ROB; consumes the ROB entries written by rename, in program order.
- Retires at most one completed instruction per cycle and maintains the retirement RAT (R-RAT).
- Returns superseded physical registers to the free list.
- On a retiring instruction with Request_Alt_PC, flushes the machine, restores the F-RAT from the R-RAT, and rebuilds the free list.

Parameters:
- NUM_ARCH, 32 (`PROJ_NUM_ARCH_REGS): architectural register count.
- NUM_PHYS, 64: physical register count.
- LOG_ARCH, 5 (`PROJ_LOG_ARCH): architectural register index width.
- LOG_PHYS, 6 (`PROJ_LOG_PHYS): physical register index width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-low reset, sampled on posedge CLK.
- ROB_head_valid  in  1  ROB is non-empty.
- ROB_head_entry  in  `ROB_ENTRY_BITS  head entry, MSB->LSB: {done, instr[31:0], addr[31:0], alt_pc[31:0], request_alt_pc, has_dest, phys[LOG_PHYS], arch[LOG_ARCH]}.
- ROB_pop  out  1  combinational; the ROB advances its head on this edge.
- Free_push  out  1  registered; push Free_reg onto the free list.
- Free_reg  out  LOG_PHYS  register being freed.
- Free_list_clear  out  1  registered pulse; empty the free list.
- Frat_restore  out  1  registered pulse; F-RAT loads Rrat_map.
- Busy_clear  out  1  registered pulse; clear the busy list.
- Flush  out  1  registered pulse; squash the ROB, issue queue, LS queue and ID FIFO.
- Redirect_valid  out  1  registered pulse; fetch restarts at Redirect_PC.
- Redirect_PC  out  32  recovery PC.
- Rrat_map  out  NUM_ARCH x LOG_PHYS  current R-RAT contents.
- Rebuilding  out  1  high in the FLUSH and REBUILD states.
- Retired_count  out  32  instructions retired since reset; wraps.

Behaviour:
- Reset (RESET==0 at posedge):
  - state=RUN; Rrat_map[i]=i; Mapped[i]=1 for i<NUM_ARCH, else 0.
  - Retired_count=0; walk counter=0; all pulse outputs 0; Free_reg=0; Redirect_PC=0.
  - Reset overrides every state, including mid-REBUILD; pushes stop on the next cycle.
- Internal state: Mapped[NUM_PHYS] bit vector, set iff the physical register is named in the R-RAT.
- RUN state:
  - ROB_pop = ROB_head_valid & done & (state==RUN).
  - On pop, with h = has_dest, a = arch, p = phys:
  - h & a!=0 & p!=Rrat_map[a]: Rrat_map[a]<=p; Mapped[p]<=1; Mapped[old]<=0; next cycle Free_push=1, Free_reg=old, where old is the pre-update Rrat_map[a].
  - h & a!=0 & p==Rrat_map[a]: no change, no push.
  - h & a==0: R-RAT untouched; push p (the register grabbed for $0 is returned).
  - !h: no RAT or free-list activity.
  - Retired_count increments by 1 on every pop.
  - If request_alt_pc is set: latch alt_pc into Redirect_PC; state becomes FLUSH. The register update above still applies: the mispredicted instruction itself commits.
- FLUSH state (exactly 1 cycle):
  - Flush, Redirect_valid, Frat_restore, Busy_clear and Free_list_clear are all 1.
  - ROB_pop=0; walk counter<=0; next state REBUILD.
- REBUILD state (NUM_PHYS cycles):
  - Each cycle, for index k = walk counter: if !Mapped[k], register a push of k, so Free_push=1 and Free_reg=k one cycle later.
  - Counter increments by 1.
  - At k==NUM_PHYS-1, go to RUN; the last push appears in the first RUN cycle.
  - ROB_pop=0 throughout.
  - Exactly NUM_PHYS-NUM_ARCH pushes occur over the rebuild.
- Single-cycle pulses: Free_push fires at most once per cycle. A retire-push and a rebuild-push can never coincide, because no pop happens in FLUSH/REBUILD.
- Head not done or ROB empty: no pop, no outputs change except pulses dropping to 0.
- Redirect_PC holds its value until the next misprediction.

Decomposition:
- Shared package (config.v): ROB entry field offsets and widths (ROB_DONE_BIT, ROB_ALTPC_LSB, ...), `ROB_ENTRY_BITS, the RUN/FLUSH/REBUILD state encoding.
- These offsets are shared with rename and the ROB.
- One sub-module: rrat (R-RAT array plus the Mapped vector).
  - One write port (arch, phys), which returns the old mapping combinationally.
  - Exposes the Rrat_map and Mapped vectors.

Test Plan:
- Reset -> Rrat_map[5]=5, Rrat_map[31]=31, Retired_count=0, Free_push=0, ROB_pop=0.
- Head {done=1, has_dest=1, arch=3, phys=40} -> ROB_pop=1 the same cycle; next cycle Free_push=1, Free_reg=3, Rrat_map[3]=40, Retired_count=1.
- Head valid with done=0 for 5 cycles, then done=1 -> ROB_pop low for 5 cycles, then high for 1 cycle; no spurious pushes.
- Head {done=1, has_dest=1, arch=0, phys=45} -> Free_push with Free_reg=45; Rrat_map[0]=0 unchanged.
- Retire arch=3/phys=40, then a branch with request_alt_pc=1, alt_pc=0x00400100:
  - Flush, Redirect_valid, Frat_restore and Free_list_clear each pulse for 1 cycle; Redirect_PC=0x00400100.
  - Rebuilding is high for 65 cycles, with exactly 32 pushes; 40 is excluded and 3 is included.
  - ROB_pop stays 0 throughout, then normal retirement resumes.
- RESET low at rebuild cycle 10 -> the next cycle is RUN, Free_push=0, Rrat_map is the identity map, and Retired_count=0.
